sram_access_arbiter: RTL and testbench

Shares the single off-chip SRAM between two requesters: port 0, the real-time capture/display path (frame saver), and port 1, the internal photo-processing path.
- Issues one 16-bit SRAM access per cycle.
- Returns read data through a fixed-latency pipeline.
- Inserts a one-cycle bus turnaround on read/write direction changes.
- Bounds port-1 starvation.

Sits between both requesters and the SRAM pins (dual-port data style: separate out/in buses).

---
 rtl/sram_arb_pkg.sv | 25 ++
 rtl/sram_rd_tag_pipe.sv | 53 +++++
 rtl/sram_access_arbiter.sv | 136 +++++++++++++
 tb/tb_sram_access_arbiter.sv | 268 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/sram_arb_pkg.sv
// Shared types and constants for the two-port SRAM access arbiter.
package sram_arb_pkg;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RD   = 2'd1,
        S_WR   = 2'd2
    } arb_state_e;

    typedef enum logic {
        P_CAP  = 1'b0,
        P_PROC = 1'b1
    } port_id_e;

    // Read-return tag carried alongside an issued read
    typedef struct packed {
        logic     valid;
        port_id_e port;
    } rd_tag_t;

    localparam logic SRAM_WE_N_IDLE = 1'b1;
    localparam logic SRAM_OE_N_IDLE = 1'b1;
    localparam logic SRAM_SEL_N_ON  = 1'b0;

endpackage

// File: rtl/sram_rd_tag_pipe.sv
// Two-stage read-return pipeline: tags follow each read, SRAM data is steered
// to the issuing port only and the other port's data is left untouched.
module sram_rd_tag_pipe
    import sram_arb_pkg::*;
#(
    parameter int unsigned DATA_W = 16
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  rd_tag_t           tag_i,
    input  logic [DATA_W-1:0] sram_data_i,
    output logic [DATA_W-1:0] p0_rdata_o,
    output logic [DATA_W-1:0] p1_rdata_o,
    output logic              p0_rvalid_o,
    output logic              p1_rvalid_o
);

    rd_tag_t           tag_s1_q;
    logic              p0_rvalid_q, p0_rvalid_d;
    logic              p1_rvalid_q, p1_rvalid_d;
    logic [DATA_W-1:0] p0_rdata_q, p0_rdata_d;
    logic [DATA_W-1:0] p1_rdata_q, p1_rdata_d;

    // Stage 2 decodes the stage-1 tag while the SRAM drives its data
    always_comb begin
        p0_rvalid_d = tag_s1_q.valid && (tag_s1_q.port == P_CAP);
        p1_rvalid_d = tag_s1_q.valid && (tag_s1_q.port == P_PROC);
        p0_rdata_d  = p0_rvalid_d ? sram_data_i : p0_rdata_q;
        p1_rdata_d  = p1_rvalid_d ? sram_data_i : p1_rdata_q;
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            tag_s1_q    <= '0;
            p0_rvalid_q <= 1'b0;
            p1_rvalid_q <= 1'b0;
            p0_rdata_q  <= '0;
            p1_rdata_q  <= '0;
        end else begin
            tag_s1_q    <= tag_i;
            p0_rvalid_q <= p0_rvalid_d;
            p1_rvalid_q <= p1_rvalid_d;
            p0_rdata_q  <= p0_rdata_d;
            p1_rdata_q  <= p1_rdata_d;
        end
    end

    assign p0_rdata_o  = p0_rdata_q;
    assign p1_rdata_o  = p1_rdata_q;
    assign p0_rvalid_o = p0_rvalid_q;
    assign p1_rvalid_o = p1_rvalid_q;

endmodule

// File: rtl/sram_access_arbiter.sv
// Shares one SRAM between the capture path (port 0) and the processing path
// (port 1): one access per cycle, turnaround bubble, bounded port-1 starvation.
module sram_access_arbiter
    import sram_arb_pkg::*;
#(
    parameter int unsigned ADDR_W     = 20,
    parameter int unsigned DATA_W     = 16,
    parameter int unsigned MAX_P0_RUN = 8
) (
    input  logic              iCLK,
    input  logic              iRST,
    input  logic              iP0_Req,
    input  logic              iP0_We,
    input  logic [ADDR_W-1:0] iP0_Addr,
    input  logic [DATA_W-1:0] iP0_WData,
    input  logic              iP1_Req,
    input  logic              iP1_We,
    input  logic [ADDR_W-1:0] iP1_Addr,
    input  logic [DATA_W-1:0] iP1_WData,
    output logic              oP0_Gnt,
    output logic              oP1_Gnt,
    output logic [DATA_W-1:0] oP0_RData,
    output logic [DATA_W-1:0] oP1_RData,
    output logic              oP0_RValid,
    output logic              oP1_RValid,
    output logic [ADDR_W-1:0] oSRAM_Addr,
    output logic [DATA_W-1:0] oSRAM_Out,
    input  logic [DATA_W-1:0] iSRAM_In,
    output logic              oSRAM_CE_N,
    output logic              oSRAM_UB_N,
    output logic              oSRAM_LB_N,
    output logic              oSRAM_OE_N,
    output logic              oSRAM_WE_N,
    output logic [1:0]        oState
);

    localparam int unsigned    RUN_W   = $clog2(MAX_P0_RUN + 1);
    localparam logic [RUN_W-1:0] RUN_MAX = RUN_W'(MAX_P0_RUN);

    arb_state_e        state_q, state_d;
    logic [RUN_W-1:0]  run_cnt_q, run_cnt_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [DATA_W-1:0] wdata_q, wdata_d;
    logic              we_n_q, we_n_d;
    logic              oe_n_q, oe_n_d;

    logic              p1_forced;
    logic              win_valid;
    port_id_e          win_port;
    logic              win_we;
    logic              conflict;
    logic              p0_gnt, p1_gnt;
    rd_tag_t           tag_d;

    // Winner selection, direction check, next bus cycle and starvation count
    always_comb begin
        state_d   = S_IDLE;
        run_cnt_d = run_cnt_q;
        addr_d    = addr_q;
        wdata_d   = '0;
        we_n_d    = SRAM_WE_N_IDLE;
        oe_n_d    = SRAM_OE_N_IDLE;
        p0_gnt    = 1'b0;
        p1_gnt    = 1'b0;
        tag_d     = '0;

        p1_forced = iP1_Req && (run_cnt_q == RUN_MAX);
        win_valid = iP0_Req || iP1_Req;
        win_port  = (iP0_Req && !p1_forced) ? P_CAP : P_PROC;
        win_we    = (win_port == P_CAP) ? iP0_We : iP1_We;
        conflict  = ((state_q == S_RD) && win_we) || ((state_q == S_WR) && !win_we);

        // A conflicting winner gets a bubble; the loser never takes its slot
        if (!iRST && win_valid && !conflict) begin
            p0_gnt     = (win_port == P_CAP);
            p1_gnt     = (win_port == P_PROC);
            state_d    = win_we ? S_WR : S_RD;
            addr_d     = (win_port == P_CAP) ? iP0_Addr : iP1_Addr;
            wdata_d    = !win_we ? '0 : ((win_port == P_CAP) ? iP0_WData : iP1_WData);
            we_n_d     = !win_we;
            oe_n_d     = win_we;
            tag_d.valid = !win_we;
            tag_d.port  = win_port;
        end

        // Count holds through a bubble so a forced port-1 win persists
        if (!iP1_Req || p1_gnt) begin
            run_cnt_d = '0;
        end else if (p0_gnt && (run_cnt_q != RUN_MAX)) begin
            run_cnt_d = run_cnt_q + RUN_W'(1);
        end
    end

    always_ff @(posedge iCLK) begin
        if (iRST) begin
            state_q   <= S_IDLE;
            run_cnt_q <= '0;
            addr_q    <= '0;
            wdata_q   <= '0;
            we_n_q    <= SRAM_WE_N_IDLE;
            oe_n_q    <= SRAM_OE_N_IDLE;
        end else begin
            state_q   <= state_d;
            run_cnt_q <= run_cnt_d;
            addr_q    <= addr_d;
            wdata_q   <= wdata_d;
            we_n_q    <= we_n_d;
            oe_n_q    <= oe_n_d;
        end
    end

    sram_rd_tag_pipe #(
        .DATA_W (DATA_W)
    ) u_rd_tag_pipe (
        .clk_i       (iCLK),
        .rst_i       (iRST),
        .tag_i       (tag_d),
        .sram_data_i (iSRAM_In),
        .p0_rdata_o  (oP0_RData),
        .p1_rdata_o  (oP1_RData),
        .p0_rvalid_o (oP0_RValid),
        .p1_rvalid_o (oP1_RValid)
    );

    assign oP0_Gnt    = p0_gnt;
    assign oP1_Gnt    = p1_gnt;
    assign oSRAM_Addr = addr_q;
    assign oSRAM_Out  = wdata_q;
    assign oSRAM_WE_N = we_n_q;
    assign oSRAM_OE_N = oe_n_q;
    assign oSRAM_CE_N = SRAM_SEL_N_ON;
    assign oSRAM_UB_N = SRAM_SEL_N_ON;
    assign oSRAM_LB_N = SRAM_SEL_N_ON;
    assign oState     = state_q;

endmodule

// File: tb/tb_sram_access_arbiter.sv
// Directed and randomized checks of sram_access_arbiter against a
// transaction-level model of grants, SRAM contents and read returns.
module tb_sram_access_arbiter;

    localparam int unsigned AW   = 20;
    localparam int unsigned DW   = 16;
    localparam int          MAXR = 8;

    logic          clk = 1'b0;
    logic          rst;
    logic          p0_req, p0_we, p1_req, p1_we;
    logic [AW-1:0] p0_addr, p1_addr;
    logic [DW-1:0] p0_wdata, p1_wdata;
    logic          gnt0, gnt1, rv0, rv1;
    logic [DW-1:0] rd0, rd1;
    logic [AW-1:0] s_addr;
    logic [DW-1:0] s_out, sram_in;
    logic          ce_n, ub_n, lb_n, oe_n, we_n;
    logic [1:0]    st;

    always #5 clk = ~clk;

    sram_access_arbiter #(.ADDR_W(AW), .DATA_W(DW), .MAX_P0_RUN(MAXR)) dut (
        .iCLK(clk), .iRST(rst),
        .iP0_Req(p0_req), .iP0_We(p0_we), .iP0_Addr(p0_addr), .iP0_WData(p0_wdata),
        .iP1_Req(p1_req), .iP1_We(p1_we), .iP1_Addr(p1_addr), .iP1_WData(p1_wdata),
        .oP0_Gnt(gnt0), .oP1_Gnt(gnt1),
        .oP0_RData(rd0), .oP1_RData(rd1), .oP0_RValid(rv0), .oP1_RValid(rv1),
        .oSRAM_Addr(s_addr), .oSRAM_Out(s_out), .iSRAM_In(sram_in),
        .oSRAM_CE_N(ce_n), .oSRAM_UB_N(ub_n), .oSRAM_LB_N(lb_n),
        .oSRAM_OE_N(oe_n), .oSRAM_WE_N(we_n), .oState(st)
    );

    typedef struct {
        int            port;
        logic [DW-1:0] data;
        int            due;
    } ret_t;

    int            cyc, checks, errs;
    int            m_dir;           // 0 none, 1 read, 2 write issued last cycle
    int            m_run;           // port-0 grants while port 1 waits
    logic [AW-1:0] m_addr;
    logic [DW-1:0] m_out;
    logic          m_we_n, m_oe_n;
    logic [DW-1:0] m_rdata [2];
    ret_t          rq [$];
    logic [DW-1:0] ref_mem  [int];
    logic [DW-1:0] sram_mem [int];
    logic          g0, g1;

    function automatic logic [DW-1:0] bg(input logic [AW-1:0] a);
        return DW'((32'(a) * 32'd40503) ^ 32'h00005a5a);
    endfunction

    function automatic logic [DW-1:0] ref_rd(input logic [AW-1:0] a);
        if (ref_mem.exists(int'(a))) return ref_mem[int'(a)];
        return bg(a);
    endfunction

    function automatic logic [DW-1:0] sram_rd(input logic [AW-1:0] a);
        if (sram_mem.exists(int'(a))) return sram_mem[int'(a)];
        return bg(a);
    endfunction

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] want);
        checks++;
        assert (got === want) else begin
            errs++;
            $error("FAIL %s cyc=%0d observed=%0h expected=%0h", tag, cyc, got, want);
        end
    endtask

    task automatic model_reset();
        m_dir = 0; m_run = 0; m_addr = '0; m_out = '0; m_we_n = 1'b1; m_oe_n = 1'b1;
        m_rdata[0] = '0; m_rdata[1] = '0;
        rq.delete();
    endtask

    // One clock cycle: check at negedge, act as the SRAM, advance the model at posedge
    task automatic step();
        bit            e0, e1, ev0, ev1, fr, wwe, we;
        int            wport;
        logic [AW-1:0] a;
        logic [DW-1:0] wd;
        ret_t          r;
        e0 = 1'b0; e1 = 1'b0; ev0 = 1'b0; ev1 = 1'b0; wwe = 1'b0; wport = -1;
        @(negedge clk);
        if (!rst) begin
            fr = p1_req && (m_run == MAXR);
            if (p0_req && !fr) begin wport = 0; wwe = p0_we; end
            else if (p1_req) begin wport = 1; wwe = p1_we; end
            if (wport >= 0 && !((m_dir == 1 && wwe) || (m_dir == 2 && !wwe))) begin
                e0 = (wport == 0);
                e1 = (wport == 1);
            end
        end
        while (rq.size() > 0 && rq[0].due == cyc) begin
            r = rq.pop_front();
            m_rdata[r.port] = r.data;
            if (r.port == 0) ev0 = 1'b1; else ev1 = 1'b1;
        end
        chk("gnt0", 32'(gnt0), 32'(e0));
        chk("gnt1", 32'(gnt1), 32'(e1));
        chk("state", 32'(st), 32'(m_dir));
        chk("sram_addr", 32'(s_addr), 32'(m_addr));
        chk("sram_out", 32'(s_out), 32'(m_out));
        chk("we_n", 32'(we_n), 32'(m_we_n));
        chk("oe_n", 32'(oe_n), 32'(m_oe_n));
        chk("ce_ub_lb", 32'({ce_n, ub_n, lb_n}), 32'(0));
        chk("rvalid0", 32'(rv0), 32'(ev0));
        chk("rvalid1", 32'(rv1), 32'(ev1));
        chk("rdata0", 32'(rd0), 32'(m_rdata[0]));
        chk("rdata1", 32'(rd1), 32'(m_rdata[1]));
        g0 = gnt0;
        g1 = gnt1;
        if (we_n === 1'b0) sram_mem[int'(s_addr)] = s_out;
        sram_in = (oe_n === 1'b0) ? sram_rd(s_addr) : '0;
        @(posedge clk);
        if (rst) begin
            model_reset();
        end else begin
            if (e0 || e1) begin
                a  = e0 ? p0_addr : p1_addr;
                we = e0 ? p0_we : p1_we;
                wd = e0 ? p0_wdata : p1_wdata;
                m_dir = we ? 2 : 1;
                m_addr = a; m_out = we ? wd : '0; m_we_n = !we; m_oe_n = we;
                if (we) ref_mem[int'(a)] = wd;
                else begin
                    r.port = e0 ? 0 : 1; r.data = ref_rd(a); r.due = cyc + 2;
                    rq.push_back(r);
                end
            end else begin
                m_dir = 0; m_out = '0; m_we_n = 1'b1; m_oe_n = 1'b1;
            end
            if (!p1_req || e1) m_run = 0;
            else if (e0 && m_run < MAXR) m_run++;
        end
        cyc++;
        #1;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step();
    endtask

    // Hold a request on one port until granted; reports the cycles it took
    task automatic op(input int port, input bit we, input logic [AW-1:0] a,
                      input logic [DW-1:0] d, output int n);
        bit got;
        n = 0; got = 1'b0;
        if (port == 0) begin p0_req = 1'b1; p0_we = we; p0_addr = a; p0_wdata = d; end
        else begin p1_req = 1'b1; p1_we = we; p1_addr = a; p1_wdata = d; end
        while (!got && n < 30) begin
            step();
            n++;
            got = (port == 0) ? g0 : g1;
        end
        chk("op_granted", 32'(got), 32'(1));
        if (port == 0) p0_req = 1'b0; else p1_req = 1'b0;
    endtask

    initial begin
        int n, a, p0_since, wait1, maxw;
        cyc = 0; checks = 0; errs = 0; g0 = 1'b0; g1 = 1'b0; sram_in = '0;
        rst = 1'b1;
        p0_req = 1'b0; p0_we = 1'b0; p0_addr = '0; p0_wdata = '0;
        p1_req = 1'b0; p1_we = 1'b0; p1_addr = '0; p1_wdata = '0;
        repeat (2) @(posedge clk);
        #1;
        model_reset();

        // Reset holds grants low even with both ports requesting
        p0_req = 1'b1; p1_req = 1'b1; p1_we = 1'b1;
        idle(3);
        p0_req = 1'b0; p1_req = 1'b0; p1_we = 1'b0;
        rst = 1'b0;

        // Port-0 back-to-back reads 0x10..0x13
        a = 'h10; n = 0;
        p0_req = 1'b1; p0_we = 1'b0; p0_addr = AW'(a);
        while (a <= 'h13 && n < 30) begin
            step(); n++;
            if (g0) begin a++; p0_addr = AW'(a); end
        end
        p0_req = 1'b0;
        chk("p0_burst_cycles", 32'(n), 32'(4));
        idle(3);

        // Write then immediate read: one turnaround bubble, data returns
        op(0, 1'b1, AW'('h20), 16'hA5C3, n);
        op(0, 1'b0, AW'('h20), '0, n);
        chk("turnaround_cycles", 32'(n), 32'(2));
        idle(3);
        chk("wr_rd_data", 32'(rd0), 32'(16'hA5C3));

        // Both ports reading continuously: runs of MAXR port-0 grants
        p0_req = 1'b1; p0_we = 1'b0; p0_addr = AW'($urandom_range(0, 63));
        p1_req = 1'b1; p1_we = 1'b0; p1_addr = AW'($urandom_range(0, 63));
        p0_since = 0; wait1 = 0; maxw = 0;
        for (int i = 0; i < 60; i++) begin
            step();
            if (g0) begin p0_since++; p0_addr = AW'($urandom_range(0, 63)); end
            if (g1) begin
                chk("p0_run_len", 32'(p0_since), 32'(MAXR));
                p0_since = 0; wait1 = 0;
                p1_addr = AW'($urandom_range(0, 63));
            end else begin
                wait1++;
                if (wait1 > maxw) maxw = wait1;
            end
        end
        chk("p1_wait_bound", 32'(maxw <= MAXR), 32'(1));
        p0_req = 1'b0; p1_req = 1'b0;
        idle(3);

        // Forced port-1 write against a port-0 read stream
        p0_req = 1'b1; p0_we = 1'b0; p0_addr = AW'('h40);
        p1_req = 1'b1; p1_we = 1'b1; p1_addr = AW'('h41); p1_wdata = 16'h3C5A;
        n = 0;
        while (!g1 && n < 30) begin
            step(); n++;
            if (g0) p0_addr = AW'($urandom_range(0, 63));
        end
        chk("forced_wr_cycles", 32'(n), 32'(MAXR + 2));
        p1_req = 1'b0;
        idle(6);
        p0_req = 1'b0;
        idle(3);

        // Reset one cycle after a read grant discards the read
        op(0, 1'b0, AW'('h41), '0, n);
        rst = 1'b1;
        step();
        rst = 1'b0;
        idle(3);
        op(0, 1'b0, AW'('h41), '0, n);
        chk("post_rst_grant_cycles", 32'(n), 32'(1));
        idle(3);
        chk("post_rst_read", 32'(rd0), 32'(16'h3C5A));

        // Randomized traffic with occasional reset
        p0_req = 1'b0; p1_req = 1'b0; g0 = 1'b0; g1 = 1'b0;
        for (int i = 0; i < 800; i++) begin
            if (!p0_req || g0) begin
                p0_req = ($urandom_range(0, 2) != 0);
                p0_we = ($urandom_range(0, 2) == 0);
                p0_addr = AW'($urandom_range(0, 63));
                p0_wdata = DW'($urandom);
            end
            if (!p1_req || g1) begin
                p1_req = ($urandom_range(0, 2) != 0);
                p1_we = ($urandom_range(0, 2) == 0);
                p1_addr = AW'($urandom_range(0, 63));
                p1_wdata = DW'($urandom);
            end
            rst = ($urandom_range(0, 99) == 0);
            step();
        end
        rst = 1'b0; p0_req = 1'b0; p1_req = 1'b0;
        idle(4);

        $display("== %0d vectors applied, %0d miscompares ==", checks, errs);
        $finish;
    end

endmodule
